// File: rtl/sized_numbers_pkg.sv
// -----------------------------------------------------------------------------
// sized_numbers_pkg
//
// Shared widths, the serializer FSM state type and the bit-ordering helper
// used by the sized-number frame serializer and its shifter.
//
// Contents:
//   BI_W, HEX_W, FRAME_W  field and frame widths (6 + 16 = 22 bits)
//   CNT_W, LAST_POS       bit-position counter width and final position (21)
//   state_t               IDLE / SHIFT / PARITY
//   frame_t               one captured frame word
//   bit_index()           maps a serial position to a frame bit index
// -----------------------------------------------------------------------------
package sized_numbers_pkg;

    localparam int BI_W    = 6;
    localparam int HEX_W   = 16;
    localparam int FRAME_W = BI_W + HEX_W;
    localparam int CNT_W   = 5;

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    typedef logic [FRAME_W-1:0] frame_t;

    // Serial position 0 is the first bit on the wire. MSB-first sends frame
    // bit 21 at position 0; LSB-first sends frame bit 0 at position 0.
    function automatic logic [CNT_W-1:0] bit_index(input logic [CNT_W-1:0] pos,
                                                   input bit               msb_first);
        return msb_first ? (LAST_POS - pos) : pos;
    endfunction

endpackage

// File: rtl/sized_frame_serializer_if.sv
// -----------------------------------------------------------------------------
// sized_frame_serializer_if
//
// Bundles the word handshake, the serial output and the status signals of the
// sized-number frame serializer.
//
// Handshake: a word moves on every rising clk edge where in_valid and in_ready
// are both 1. in_valid, bi_in and hex_in are only looked at while in_ready=1;
// the serial side has no back-pressure, ser_out is meaningful only while
// ser_valid=1 and is forced to 0 otherwise.
//
// Signals:
//   in_valid, bi_in[5:0], hex_in[15:0]   upstream word (master -> slave)
//   in_ready                             serializer can take a word
//   ser_out, ser_valid, frame_start      serial stream
//   busy, frame_count[7:0]               status
//   state                                FSM state, for observation only
//
// Modports: master = upstream/observer side, slave = the serializer.
// -----------------------------------------------------------------------------
interface sized_frame_serializer_if;
    import sized_numbers_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BI_W-1:0]  bi_in;
    logic [HEX_W-1:0] hex_in;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             busy;
    logic [7:0]       frame_count;
    state_t           state;

    modport master (
        output in_valid, bi_in, hex_in,
        input  in_ready, ser_out, ser_valid, frame_start, busy, frame_count, state
    );

    modport slave (
        input  in_valid, bi_in, hex_in,
        output in_ready, ser_out, ser_valid, frame_start, busy, frame_count, state
    );

endinterface

// File: rtl/frame_shifter.sv
// -----------------------------------------------------------------------------
// frame_shifter
//
// Holds the captured frame, the serial bit-position counter and the running
// parity of the bits already sent. The frame register is never shifted: the
// counter selects bits out of it, so the captured word stays intact for the
// whole frame.
//
// The serializer registers its outputs, so this block presents the bit that
// goes on the wire in the *next* cycle:
//   first_bit  bit at position 0 of the word currently on the input (load)
//   next_bit   bit at position cnt+1 of the stored frame (0 at the last bit)
//   last       cnt is at position 21, i.e. the final data bit is on the wire
//   parity     XOR of every bit sent so far; at 'last' it covers all 22 bits
//
// Ports:
//   clk, rst    clock and synchronous active-high reset (wins over load)
//   load        capture 'word' and restart at position 0
//   step        advance one position
//   word        frame to capture
// -----------------------------------------------------------------------------
module frame_shifter
    import sized_numbers_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   step,
    input  frame_t word,
    output logic   first_bit,
    output logic   next_bit,
    output logic   last,
    output logic   parity
);

    frame_t           frame;
    logic [CNT_W-1:0] cnt;
    logic             par_acc;
    logic [CNT_W-1:0] next_pos;

    assign last      = (cnt == LAST_POS);
    assign first_bit = word[bit_index('0, MSB_FIRST)];

    // Hold the position at the last bit so the index never leaves 0..21.
    assign next_pos  = last ? cnt : cnt + CNT_W'(1);
    assign next_bit  = last ? 1'b0 : frame[bit_index(next_pos, MSB_FIRST)];
    assign parity    = par_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame   <= '0;
            cnt     <= '0;
            par_acc <= 1'b0;
        end else if (load) begin
            frame   <= word;
            cnt     <= '0;
            // Position 0 goes on the wire right after the load, so it is
            // already part of the running parity.
            par_acc <= first_bit;
        end else if (step) begin
            cnt     <= next_pos;
            par_acc <= par_acc ^ next_bit;
        end
    end

endmodule

// File: rtl/sized_frame_serializer.sv
// -----------------------------------------------------------------------------
// sized_frame_serializer
//
// Takes a 22-bit {bi_in, hex_in} word from the upstream sized-number stage and
// sends it out one bit per cycle, followed by an even-parity bit, giving a
// 23-cycle frame. A new word can be accepted during the parity cycle so
// back-to-back frames leave no gap on ser_valid.
//
// FSM:
//   IDLE    in_ready=1, nothing on the wire
//   SHIFT   22 data bits, in_ready=0 (inputs ignored)
//   PARITY  parity bit, in_ready=1; a transfer here starts the next frame
//
// All outputs are registered: each is computed one cycle ahead from the next
// state, so the first data bit appears the cycle after the transfer.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset; beats a coincident transfer
//   bus   sized_frame_serializer_if.slave (handshake, serial out, status)
//
// Parameter:
//   MSB_FIRST  1: frame bit 21 first; 0: frame bit 0 first
// -----------------------------------------------------------------------------
module sized_frame_serializer
    import sized_numbers_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    sized_frame_serializer_if.slave  bus
);

    state_t     state;
    logic       in_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       frame_start;
    logic       busy;
    logic [7:0] frame_count;

    frame_t     word;
    logic       transfer;
    logic       step;
    logic       first_bit;
    logic       next_bit;
    logic       last;
    logic       parity;

    assign word     = {bus.bi_in, bus.hex_in};
    assign transfer = bus.in_valid && in_ready;
    assign step     = (state == SHIFT) && !last;

    frame_shifter #(
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (transfer),
        .step      (step),
        .word      (word),
        .first_bit (first_bit),
        .next_bit  (next_bit),
        .last      (last),
        .parity    (parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state       <= SHIFT;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        ser_valid   <= 1'b1;
                        frame_start <= 1'b1;
                        ser_out     <= first_bit;
                    end
                end

                SHIFT: begin
                    if (last) begin
                        state    <= PARITY;
                        in_ready <= 1'b1;
                        ser_out  <= parity;
                    end else begin
                        ser_out  <= next_bit;
                    end
                end

                PARITY: begin
                    // The frame completes as this cycle ends.
                    frame_count <= frame_count + 8'd1;
                    if (transfer) begin
                        // Chain straight into the next frame; ser_valid and
                        // busy stay high.
                        state       <= SHIFT;
                        in_ready    <= 1'b0;
                        frame_start <= 1'b1;
                        ser_out     <= first_bit;
                    end else begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_out   <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    ser_valid <= 1'b0;
                    ser_out   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.ser_out     = ser_out;
    assign bus.ser_valid   = ser_valid;
    assign bus.frame_start = frame_start;
    assign bus.busy        = busy;
    assign bus.frame_count = frame_count;
    assign bus.state       = state;

endmodule

// File: tb/tb_sized_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_sized_frame_serializer
//
// Drives an MSB-first and an LSB-first serializer. Expected serial streams are
// built from the word itself: data bits in wire order, then XOR of the word.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sized_frame_serializer;
    import sized_numbers_pkg::*;

    localparam logic [21:0] W1 = {6'b101001, 16'hea75};
    localparam logic [21:0] W2 = {6'b011010, 16'hfb17};

    typedef struct {
        logic       so;
        logic       sv;
        logic       fs;
        logic       rdy;
        logic       bsy;
        logic [7:0] fc;
        state_t     st;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_frames [2];

    always #5 clk = ~clk;

    sized_frame_serializer_if bus_m ();
    sized_frame_serializer_if bus_l ();

    sized_frame_serializer #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    sized_frame_serializer #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    // ---------------- reference model ----------------
    // Position k of a frame: k<22 is a data bit in wire order, k==22 parity.
    function automatic logic model_bit(input logic [21:0] w, input int k, input bit msb);
        if (k == FRAME_W) return ^w;
        return msb ? w[FRAME_W-1-k] : w[k];
    endfunction

    function automatic obs_t sample(input bit l);
        obs_t o;
        if (l) begin
            o.so = bus_l.ser_out; o.sv = bus_l.ser_valid; o.fs = bus_l.frame_start;
            o.rdy = bus_l.in_ready; o.bsy = bus_l.busy; o.fc = bus_l.frame_count; o.st = bus_l.state;
        end else begin
            o.so = bus_m.ser_out; o.sv = bus_m.ser_valid; o.fs = bus_m.frame_start;
            o.rdy = bus_m.in_ready; o.bsy = bus_m.busy; o.fc = bus_m.frame_count; o.st = bus_m.state;
        end
        return o;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit l, input logic v, input logic [21:0] w);
        if (l) begin
            bus_l.in_valid = v; bus_l.bi_in = w[21:16]; bus_l.hex_in = w[15:0];
        end else begin
            bus_m.in_valid = v; bus_m.bi_in = w[21:16]; bus_m.hex_in = w[15:0];
        end
    endtask

    // Called on a falling edge; returns on the falling edge where the first
    // bit of the accepted word is on the wire.
    task automatic accept(input bit l, input logic [21:0] w);
        int   guard;
        obs_t o;
        guard = 0;
        drive(l, 1'b1, w);
        o = sample(l);
        while (o.rdy !== 1'b1 && guard < 40) begin
            @(negedge clk);
            o = sample(l);
            guard++;
        end
        if (guard >= 40) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", o.rdy, guard);
        end
        n_checks++;
        @(negedge clk);
        drive(l, 1'b0, w);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        repeat (3) @(negedge clk);
        o = sample(1'b0);
        if (o.so !== 1'b0) begin n_fail++; $display("FAIL reset_ser_out: got %b want 0", o.so); end
        n_checks++;
        if (o.sv !== 1'b0) begin n_fail++; $display("FAIL reset_ser_valid: got %b want 0", o.sv); end
        n_checks++;
        if (o.fs !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", o.fs); end
        n_checks++;
        if (o.bsy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o.bsy); end
        n_checks++;
        if (o.fc !== 8'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", o.fc); end
        n_checks++;
        rst = 1'b0;
        exp_frames[0] = 0;
        exp_frames[1] = 0;
        @(negedge clk);
        o = sample(1'b0);
        if (o.rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", o.rdy); end
        n_checks++;
        if (o.st !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", o.st); end
        n_checks++;
    endtask

    task automatic test_frame(input bit l, input logic [21:0] w, input string name);
        obs_t o;
        logic exp_q[$];
        for (int k = 0; k <= FRAME_W; k++) exp_q.push_back(model_bit(w, k, !l));
        accept(l, w);
        for (int k = 0; k <= FRAME_W; k++) begin
            o = sample(l);
            if (o.sv !== 1'b1) begin n_fail++; $display("FAIL %s_ser_valid[%0d]: got %b want 1", name, k, o.sv); end
            n_checks++;
            if (o.so !== exp_q[k]) begin n_fail++; $display("FAIL %s_bit[%0d]: got %b want %b", name, k, o.so, exp_q[k]); end
            n_checks++;
            if (o.fs !== (k == 0)) begin n_fail++; $display("FAIL %s_frame_start[%0d]: got %b want %b", name, k, o.fs, k == 0); end
            n_checks++;
            if (o.rdy !== (k == FRAME_W)) begin n_fail++; $display("FAIL %s_in_ready[%0d]: got %b want %b", name, k, o.rdy, k == FRAME_W); end
            n_checks++;
            if (o.bsy !== 1'b1) begin n_fail++; $display("FAIL %s_busy[%0d]: got %b want 1", name, k, o.bsy); end
            n_checks++;
            @(negedge clk);
        end
        exp_frames[l]++;
        o = sample(l);
        if (o.sv !== 1'b0 || o.so !== 1'b0) begin
            n_fail++; $display("FAIL %s_after_valid: got sv=%b so=%b want 0/0", name, o.sv, o.so);
        end
        n_checks++;
        if (o.bsy !== 1'b0) begin n_fail++; $display("FAIL %s_after_busy: got %b want 0", name, o.bsy); end
        n_checks++;
        if (o.fc !== 8'(exp_frames[l])) begin
            n_fail++; $display("FAIL %s_frame_count: got %0d want %0d", name, o.fc, 8'(exp_frames[l]));
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic exp_q[$];
        for (int k = 0; k <= FRAME_W; k++) exp_q.push_back(model_bit(W1, k, 1'b1));
        for (int k = 0; k <= FRAME_W; k++) exp_q.push_back(model_bit(W2, k, 1'b1));
        drive(1'b0, 1'b1, W1);
        @(negedge clk);
        drive(1'b0, 1'b1, W2);
        for (int k = 0; k < 46; k++) begin
            o = sample(1'b0);
            if (o.sv !== 1'b1) begin n_fail++; $display("FAIL b2b_ser_valid[%0d]: got %b want 1", k, o.sv); end
            n_checks++;
            if (o.so !== exp_q[k]) begin n_fail++; $display("FAIL b2b_bit[%0d]: got %b want %b", k, o.so, exp_q[k]); end
            n_checks++;
            if (o.fs !== (k == 0 || k == 23)) begin n_fail++; $display("FAIL b2b_frame_start[%0d]: got %b", k, o.fs); end
            n_checks++;
            if (o.rdy !== (k == 22 || k == 45)) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b", k, o.rdy); end
            n_checks++;
            if (k == 23) drive(1'b0, 1'b0, W2);
            @(negedge clk);
        end
        exp_frames[0] += 2;
        o = sample(1'b0);
        if (o.sv !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b want 0", o.sv); end
        n_checks++;
        if (o.fc !== 8'(exp_frames[0])) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want %0d", o.fc, 8'(exp_frames[0])); end
        n_checks++;
    endtask

    task automatic test_input_change();
        obs_t o;
        logic exp_q[$];
        for (int k = 0; k <= FRAME_W; k++) exp_q.push_back(model_bit(W1, k, 1'b1));
        drive(1'b0, 1'b1, W1);
        @(negedge clk);
        drive(1'b0, 1'b1, {6'h3f, 16'hffff});
        for (int k = 0; k <= FRAME_W; k++) begin
            o = sample(1'b0);
            if (o.so !== exp_q[k] || o.sv !== 1'b1) begin
                n_fail++; $display("FAIL hold_bit[%0d]: got so=%b sv=%b want %b/1", k, o.so, o.sv, exp_q[k]);
            end
            n_checks++;
            if (o.rdy !== (k == FRAME_W)) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b", k, o.rdy); end
            n_checks++;
            if (k >= 1 && k <= 20) drive(1'b0, 1'($urandom_range(0, 1)), 22'($urandom));
            if (k == 21) drive(1'b0, 1'b0, '0);
            @(negedge clk);
        end
        exp_frames[0]++;
        o = sample(1'b0);
        if (o.sv !== 1'b0 || o.st !== IDLE) begin n_fail++; $display("FAIL hold_end: got sv=%b st=%0d want 0/IDLE", o.sv, o.st); end
        n_checks++;
    endtask

    task automatic test_reset_mid_frame();
        obs_t o;
        logic [21:0] w;
        w = 22'($urandom);
        accept(1'b0, w);
        for (int k = 0; k <= 10; k++) begin
            o = sample(1'b0);
            if (o.so !== model_bit(w, k, 1'b1)) begin n_fail++; $display("FAIL midrst_bit[%0d]: got %b want %b", k, o.so, model_bit(w, k, 1'b1)); end
            n_checks++;
            if (k == 10) rst = 1'b1;
            @(negedge clk);
        end
        o = sample(1'b0);
        rst = 1'b0;
        exp_frames[0] = 0;
        exp_frames[1] = 0;
        if (o.sv !== 1'b0 || o.so !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got sv=%b so=%b want 0/0", o.sv, o.so); end
        n_checks++;
        if (o.bsy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", o.bsy); end
        n_checks++;
        if (o.fc !== 8'd0) begin n_fail++; $display("FAIL midrst_frame_count: got %0d want 0", o.fc); end
        n_checks++;
        if (o.rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", o.rdy); end
        n_checks++;
        repeat (3) begin
            @(negedge clk);
            o = sample(1'b0);
            if (o.sv !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet: got sv=%b want 0", o.sv); end
            n_checks++;
        end
        test_frame(1'b0, 22'($urandom), "after_rst");
    endtask

    task automatic test_reset_vs_transfer();
        obs_t o;
        drive(1'b0, 1'b1, 22'($urandom));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, '0);
        exp_frames[0] = 0;
        exp_frames[1] = 0;
        for (int k = 0; k < 3; k++) begin
            o = sample(1'b0);
            if (o.sv !== 1'b0 || o.fs !== 1'b0 || o.bsy !== 1'b0) begin
                n_fail++; $display("FAIL rst_wins[%0d]: got sv=%b fs=%b busy=%b want 0/0/0", k, o.sv, o.fs, o.bsy);
            end
            n_checks++;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        obs_t o;
        logic [21:0] words [256];
        for (int f = 0; f < 256; f++) words[f] = 22'($urandom);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_frames[0] = 0;
        exp_frames[1] = 0;
        drive(1'b0, 1'b1, words[0]);
        @(negedge clk);
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k <= FRAME_W; k++) begin
                o = sample(1'b0);
                if (o.sv !== 1'b1 || o.so !== model_bit(words[f], k, 1'b1) || o.fs !== (k == 0)) begin
                    n_fail++;
                    $display("FAIL wrap_f%0d_bit[%0d]: got sv=%b so=%b fs=%b want 1/%b/%b",
                             f, k, o.sv, o.so, o.fs, model_bit(words[f], k, 1'b1), k == 0);
                end
                n_checks++;
                if (k == 0) begin
                    if (o.fc !== 8'(exp_frames[0])) begin
                        n_fail++; $display("FAIL wrap_count_f%0d: got %0d want %0d", f, o.fc, 8'(exp_frames[0]));
                    end
                    n_checks++;
                    if (f < 255) drive(1'b0, 1'b1, words[f+1]);
                    else         drive(1'b0, 1'b0, '0);
                end
                @(negedge clk);
            end
            exp_frames[0]++;
        end
        o = sample(1'b0);
        if (o.fc !== 8'(exp_frames[0])) begin n_fail++; $display("FAIL wrap_final_count: got %0d want %0d", o.fc, 8'(exp_frames[0])); end
        n_checks++;
        if (o.sv !== 1'b0) begin n_fail++; $display("FAIL wrap_final_valid: got %b want 0", o.sv); end
        n_checks++;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        test_reset();
        test_frame(1'b0, W1, "scen1");
        test_frame(1'b0, W2, "scen2");
        for (int i = 0; i < 6; i++) test_frame(1'b0, 22'($urandom), "rand_msb");
        test_back_to_back();
        test_input_change();
        test_reset_mid_frame();
        test_reset_vs_transfer();
        test_wrap();
        test_frame(1'b1, W1, "lsb_scen1");
        for (int i = 0; i < 4; i++) test_frame(1'b1, 22'($urandom), "rand_lsb");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
